// File: rtl/mem_arb_pkg.sv
// Shared encodings for the iCache/dCache memory port arbiter.
// State, owner and block-offset definitions used by the top and the pick logic.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } own_t;

  // 8 words of 32 bits per block, so the low 5 address bits select within a block.
  localparam int BLK_OFF_W = 5;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the two cache request ports and the memory-side port of the arbiter.
// slave: arbiter view; master: the cache/memory environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int BLK_W  = 256
);

  logic              i_req;
  logic              i_wr;
  logic [ADDR_W-1:0] i_addr;
  logic [BLK_W-1:0]  i_wdata;
  logic              i_done;

  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [BLK_W-1:0]  d_wdata;
  logic              d_done;

  logic [BLK_W-1:0]  rdata;
  logic              busy;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [BLK_W-1:0]  mem_wdata;
  logic [BLK_W-1:0]  mem_rdata;
  logic              mem_ack;

  modport slave (
    input  i_req, i_wr, i_addr, i_wdata,
    input  d_req, d_wr, d_addr, d_wdata,
    output i_done, d_done, rdata, busy,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output i_req, i_wr, i_addr, i_wdata,
    output d_req, d_wr, d_addr, d_wdata,
    input  i_done, d_done, rdata, busy,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Grant decision between iCache and dCache, plus its fairness state.
// Default: dCache priority with a starvation limit; MEM_ARB_ROUND_ROBIN_EN selects round-robin.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic d_req,
  input  logic in_idle,
  output own_t grant_own
);

`ifdef MEM_ARB_ROUND_ROBIN_EN

  own_t last_own;

  always_comb begin
    grant_own = OWN_D;
    if (i_req && d_req) begin
      grant_own = (last_own == OWN_D) ? OWN_I : OWN_D;
    end else if (i_req) begin
      grant_own = OWN_I;
    end
  end

  // Reset value OWN_I makes dCache win the first contested grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_own <= OWN_I;
    end else if (in_idle && (i_req || d_req)) begin
      last_own <= grant_own;
    end
  end

`else

  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  always_comb begin
    grant_own = OWN_D;
    if (i_req && d_req) begin
      grant_own = (starve_cnt == CNT_MAX) ? OWN_I : OWN_D;
    end else if (i_req) begin
      grant_own = OWN_I;
    end
  end

  // Counts dCache wins while iCache is waiting; saturates at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (in_idle) begin
      if (!i_req || grant_own == OWN_I) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one block-wide memory port between iCache and dCache (IDLE/GRANT/ACCESS/DONE).
// Optional macro MEM_ARB_ROUND_ROBIN_EN swaps starvation-limited dCache priority for round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int BLK_W      = 256,
  parameter int STARVE_MAX = 4
) (
  input logic             CLK,
  input logic             RESET,
  mem_port_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << BLK_OFF_W) - 1);

  state_t            state;
  state_t            state_nxt;
  own_t              grant_own;
  own_t              own_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BLK_W-1:0]  wdata_q;
  logic [BLK_W-1:0]  rdata_q;
  logic              in_idle;
  logic              take;

  assign in_idle = (state == IDLE);
  assign take    = in_idle && (bus.i_req || bus.d_req);

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk       (CLK),
    .rst_n     (RESET),
    .i_req     (bus.i_req),
    .d_req     (bus.d_req),
    .in_idle   (in_idle),
    .grant_own (grant_own)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = GRANT;
      GRANT:   state_nxt = ACCESS;
      ACCESS:  if (bus.mem_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured at grant, so a requester dropping its line later is harmless.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      own_q   <= OWN_I;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      own_q <= grant_own;
      if (grant_own == OWN_I) begin
        wr_q    <= bus.i_wr;
        addr_q  <= bus.i_addr & ~OFF_MASK;
        wdata_q <= bus.i_wdata;
      end else begin
        wr_q    <= bus.d_wr;
        addr_q  <= bus.d_addr & ~OFF_MASK;
        wdata_q <= bus.d_wdata;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rdata_q <= '0;
    end else if (state == ACCESS && bus.mem_ack && !wr_q) begin
      rdata_q <= bus.mem_rdata;
    end
  end

  always_comb begin
    bus.busy      = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.i_done    = 1'b0;
    bus.d_done    = 1'b0;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.rdata     = rdata_q;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
      end
      GRANT: begin
        bus.busy = 1'b1;
      end
      ACCESS: begin
        bus.busy   = 1'b1;
        bus.mem_rd = !wr_q;
        bus.mem_wr = wr_q;
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.i_done = (own_q == OWN_I);
        bus.d_done = (own_q == OWN_D);
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  a_done_onehot: assert property (@(posedge CLK) disable iff (!RESET)
    !(bus.i_done && bus.d_done));

  a_strobe_excl: assert property (@(posedge CLK) disable iff (!RESET)
    !(bus.mem_rd && bus.mem_wr));

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning memory address width.
REQ-002 SHALL have parameter BLK_W, default 256, meaning cache block width (8 words).
REQ-003 SHALL have parameter STARVE_MAX, default 4, meaning consecutive dCache grants tolerated while iCache waits.
REQ-004 SHALL have port CLK, input, 1, meaning single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET, input, 1, meaning asynchronous, active-low reset.
REQ-006 SHALL have ports i_req/d_req, input, 1 each, meaning iCache/dCache block request, held high until the matching done pulse.
REQ-007 SHALL have ports i_wr/d_wr, input, 1 each, meaning 1 = block write, 0 = block read.
REQ-008 SHALL have ports i_addr/d_addr, input, ADDR_W each, meaning block address; low 5 bits ignored.
REQ-009 SHALL have ports i_wdata/d_wdata, input, BLK_W each, meaning write block.
REQ-010 SHALL have ports i_done/d_done, output, 1 each, meaning one-cycle completion pulse to the owner.
REQ-011 SHALL have port rdata, output, BLK_W, meaning registered read block, valid in the done cycle.
REQ-012 SHALL have ports mem_rd/mem_wr, output, 1 each, meaning block read/write strobe to memory.
REQ-013 SHALL have ports mem_addr (ADDR_W) and mem_wdata (BLK_W), output, meaning block-aligned address (low 5 bits zero) and write block.
REQ-014 SHALL have ports mem_rdata (BLK_W) and mem_ack (1), input, meaning memory read block and completion.
REQ-015 SHALL have port busy, output, 1, meaning FSM not IDLE; ORed into pipeline FREEZE.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT, ACCESS, DONE.
REQ-017 SHALL leave IDLE for GRANT on the first edge with i_req or d_req high, latching owner, wr, address and wdata.
REQ-018 SHALL move GRANT to ACCESS unconditionally; mem_rd or mem_wr, per latched wr, SHALL be high throughout ACCESS from the following cycle.
REQ-019 SHALL stay in ACCESS until mem_ack is sampled high, then register mem_rdata (reads only) and enter DONE.
REQ-020 SHALL, in DONE, pulse exactly one of i_done/d_done for one cycle, drop both strobes, and return to IDLE.
REQ-021 SHALL give minimum latency req-to-done of 4 cycles when mem_ack is returned in the first ACCESS cycle.
REQ-022 SHALL ignore a request that drops mid-transaction; the access completes and done is still pulsed.
REQ-023 SHALL accept mem_ack only in ACCESS; mem_ack outside ACCESS has no effect.
REQ-024 SHALL, with both requests high in IDLE, grant dCache unless the starvation counter equals STARVE_MAX, in which case iCache is granted.
REQ-025 SHALL increment the saturating starvation counter on each dCache grant while i_req is high, and clear it on any iCache grant or when i_req is low in IDLE.
REQ-026 SHALL hold rdata stable between done pulses.

Reset
REQ-027 SHALL, on RESET low, immediately force IDLE; busy, mem_rd, mem_wr, i_done, d_done = 0; mem_addr, mem_wdata, rdata = 0; starvation counter = 0.
REQ-028 SHALL abandon an in-flight access on reset without a done pulse.

Configuration
REQ-029 SHALL support macro MEM_ARB_ROUND_ROBIN_EN: when defined, simultaneous requests are granted to the requester not served last (initially dCache after reset) and the starvation counter is removed; when undefined, REQ-024/025 apply.

Structure
REQ-030 SHALL place FSM state encoding, owner encoding (OWN_I, OWN_D) and block offset width (5) in a shared package mem_arb_pkg.
REQ-031 SHALL use one sub-module, mem_arb_pick, containing the combinational grant decision and the starvation/last-served state.

Verification
REQ-032 SHALL cover: d_req read of 0x00001004, mem_ack on first ACCESS cycle -> mem_addr 0x00001000, d_done 4 cycles after req, rdata = mem_rdata.
REQ-033 SHALL cover: i_req and d_req high together, macro undefined -> dCache first, iCache second; 5 back-to-back d_req with i_req held and STARVE_MAX 4 -> iCache granted fifth.
REQ-034 SHALL cover: macro defined, both held high for 4 transactions -> grants alternate D, I, D, I.
REQ-035 SHALL cover: d_wr write, mem_ack delayed 10 cycles -> mem_wr high 10 cycles, busy high throughout, d_done single pulse, rdata unchanged.
REQ-036 SHALL cover: RESET low during ACCESS -> all outputs 0 within the same cycle, no done pulse, next request served normally.
REQ-037 SHALL cover: i_req dropped in GRANT -> access completes, i_done pulses once, FSM returns to IDLE.
